// File: rtl/dxy_pkg.sv
// Shared types for the DXY inverse solver.
// State encoding, error priority and small helpers.
package dxy_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } dxy_state_t;

    localparam int DXY_ONE = 1;

    // Higher encoding wins when several faults apply.
    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_INEXACT,
        ERR_RANGE,
        ERR_DIV0
    } dxy_err_t;

    function automatic dxy_err_t dxy_pick(
        input logic div0,
        input logic range,
        input logic inexact
    );
        if (div0)
            return ERR_DIV0;
        else if (range)
            return ERR_RANGE;
        else if (inexact)
            return ERR_INEXACT;
        else
            return ERR_NONE;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit
// per cycle, MSB first, N cycles after load.
module seq_divider #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] cnt;
    logic [N-1:0]  dsr;
    logic [N:0]    trial;
    logic          fits;

    // Shift the next dividend bit into the partial remainder.
    always_comb begin
        trial = {remainder, quotient[N-1]};
        fits  = trial >= {1'b0, dsr};
    end

    // Load operands, then run one restoring step per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            dsr       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (load) begin
            cnt       <= CW'(N);
            dsr       <= divisor;
            quotient  <= dividend;
            remainder <= '0;
        end else if (cnt != '0) begin
            cnt      <= cnt - 1'b1;
            quotient <= {quotient[N-2:0], fits};
            if (fits)
                remainder <= N'(trial - {1'b0, dsr});
            else
                remainder <= trial[N-1:0];
        end
    end

    assign busy = cnt != '0;

endmodule

// File: rtl/dxy_solve.sv
// Recovers BX from (a, res) where res = a*a*(1-2*BX).
// Optional remainder port: DXY_SOLVE_RESID_EN.
module dxy_solve
    import dxy_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] res,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] bx,
    output logic         err_div0,
    output logic         err_range,
    output logic         err_inexact
`ifdef DXY_SOLVE_RESID_EN
    ,
    output logic [N-1:0] rem
`endif
);

    localparam int CW = $clog2(N);

    dxy_state_t state, nxt;
    dxy_err_t   mul_err, fix_err;

    logic [N-1:0]   a_q, res_q, mag;
    logic [N-1:0]   quo, rmd, q, bx_n;
    logic [2*N-1:0] aa;
    logic [CW-1:0]  steps;
    logic signed [N:0] diff;
    logic busy, load, neg, wrap, inexact;

    // Product, sign handling and fix-up arithmetic.
    always_comb begin
        aa      = {{N{1'b0}}, a_q} * {{N{1'b0}}, a_q};
        neg     = res_q[N-1];
        mag     = neg ? (~res_q + 1'b1) : res_q;
        mul_err = dxy_pick(aa == '0, |aa[2*N-1:N-1], 1'b0);
        load    = (state == MUL) && (mul_err == ERR_NONE);
        q       = neg ? (~quo + 1'b1) : quo;
        wrap    = quo == {1'b1, {(N-1){1'b0}}};
        inexact = (rmd != '0) || !quo[0];
        fix_err = dxy_pick(1'b0, wrap, inexact);
        diff    = $signed((N+1)'(DXY_ONE))
                - $signed({q[N-1], q});
        bx_n    = N'(diff >>> 1);
    end

    seq_divider #(.N(N)) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .dividend  (mag),
        .divisor   (aa[N-1:0]),
        .busy      (busy),
        .quotient  (quo),
        .remainder (rmd)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    // Next state and handshake.
    always_comb begin
        nxt   = state;
        ready = state == IDLE;
        unique case (state)
            IDLE: if (start) nxt = MUL;
            MUL:  nxt = (mul_err == ERR_NONE) ? DIV : IDLE;
            DIV:  if (steps == '0 || !busy) nxt = FIX;
            FIX:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Operand capture, step count and held results.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            res_q       <= '0;
            steps       <= '0;
            done        <= 1'b0;
            bx          <= '0;
            err_div0    <= 1'b0;
            err_range   <= 1'b0;
            err_inexact <= 1'b0;
`ifdef DXY_SOLVE_RESID_EN
            rem         <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    a_q         <= a;
                    res_q       <= res;
                    bx          <= '0;
                    err_div0    <= 1'b0;
                    err_range   <= 1'b0;
                    err_inexact <= 1'b0;
`ifdef DXY_SOLVE_RESID_EN
                    rem         <= '0;
`endif
                end
                MUL: begin
                    steps <= CW'(N - 1);
                    if (mul_err != ERR_NONE) begin
                        done      <= 1'b1;
                        err_div0  <= mul_err == ERR_DIV0;
                        err_range <= mul_err == ERR_RANGE;
                    end
                end
                DIV: if (steps != '0) steps <= steps - 1'b1;
                FIX: begin
                    done        <= 1'b1;
                    bx          <= wrap ? '0 : bx_n;
                    err_range   <= fix_err == ERR_RANGE;
                    err_inexact <= fix_err == ERR_INEXACT;
`ifdef DXY_SOLVE_RESID_EN
                    rem         <= wrap ? '0 : rmd;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dxy_solve.md
Name: dxy_solve

Overview:
- Inverse of the SPU DXY term generator. The forward path computes res = a·a·(1−2·BX) mod 2^N.
- This block recovers BX from a given (a, res) pair.
- Sequential: one multiply cycle, then an N-cycle restoring divide, then a fix-up cycle.
- Sits beside the DXY generator in the SPU. Used to back-solve shape parameters and to self-check DXY results.

Parameters:
- N, 16, datapath width. res and bx are signed two's complement; a is unsigned.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when ready=1
- a  input  N  unsigned shape operand
- res  input  N  signed DXY value
- ready  output  1  block can accept start
- done  output  1  one-cycle pulse; results valid from this cycle
- bx  output  N  recovered BX, signed
- err_div0  output  1  a·a == 0
- err_range  output  1  a·a ≥ 2^(N−1), so it does not fit as a positive signed N-bit value
- err_inexact  output  1  result is not an exact solution

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, ready=1.
  - done, bx and all err_* = 0.
  - Reset mid-operation aborts immediately; no done pulse is produced.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - ready=1.
  - start=1 at edge E0 latches a and res, clears all err_* and bx, then goes to MUL with ready=0.
- MUL (edge E1):
  - aa = a·a computed at full 2N width.
  - If aa==0: err_div0=1, done=1, go to IDLE.
  - Else if aa ≥ 2^(N−1): err_range=1, done=1, go to IDLE.
  - Else: load the divider with |res| and aa[N−1:0], go to DIV.
- DIV (edges E2..E(N+1)):
  - Unsigned restoring division, one quotient bit per cycle, MSB first, N iterations.
- FIX (edge E(N+2)):
  - q = |res|/aa, negated when res<0. r = |res| mod aa.
  - err_inexact=1 if r≠0 or q is even, because 1−2·BX is always odd.
  - bx = (1−q) >>> 1, arithmetic shift, computed in N bits. This is exact whenever q is odd.
  - done=1, go to IDLE.
- Latency:
  - Normal path: done after edge E(N+2), i.e. 18 cycles at N=16.
  - Error paths: done after E1.
- done:
  - Single-cycle pulse.
  - ready=1 in the same cycle as done, so a back-to-back start is accepted on the next edge.
- Holding: bx and err_* hold their values until the next accepted start, then clear at that edge.
- start while ready=0 is ignored; it is not queued.
- Input stability: a and res are captured at E0. Later input changes have no effect on the current operation.
- Wrap-around:
  - q = −2^(N−1) is not representable in the negated form. It is flagged err_range, with bx=0.
  - 1−q is computed in N+1 bits before the shift, so bx never overflows.
- Error priority: err_div0 > err_range > err_inexact. At most one err_* is set per operation.

Optional Feature:
- Macro: DXY_SOLVE_RESID_EN
- Defined:
  - Adds output port rem (N bits, unsigned), carrying the divider remainder r.
  - rem is valid with done and held like bx.
  - rem is 0 on the err_div0 and err_range paths.
- Undefined: rem port is absent. r is used only internally to drive err_inexact.

Decomposition:
- Package dxy_pkg holds:
  - state enum dxy_state_t {IDLE, MUL, DIV, FIX}
  - localparam DXY_ONE = 1
  - the error-priority encoding
- Sub-module seq_divider (parameter N):
  - Ports: clk, rst, load, dividend, divisor, busy, quotient, remainder.
  - Unsigned restoring divider, N cycles.
- dxy_solve owns: the FSM, sign handling, the multiply, and the fix-up logic.

Test Plan (N=16):
- a=3, res=16'hFFAF (−81), start → q=−9, bx=5, all err=0, done exactly 18 cycles after the start edge.
- a=1, res=1 → bx=0, no error. a=5, res=16'h004B (75): q=3 → bx=16'hFFFF (−1).
- a=0, any res → err_div0=1, bx=0, done after 2 edges. a=200 (aa=40000) → err_range=1.
- a=4, res=17 → r=1, err_inexact=1. a=2, res=8 → q=2 (even), err_inexact=1. With DXY_SOLVE_RESID_EN: rem=1 and rem=0 respectively.
- Start held high for the whole operation, with a and res changing at cycles 3..10 → exactly one done, result from the E0 values. Start in the done cycle → accepted, new done 18 cycles later.
- rst asserted at DIV cycle 7 → next cycle ready=1, done=0, bx=0, all err=0. A new start after reset completes correctly.
